// File: rtl/gin_multicast.sv
// gin_multicast: loads per-PE XID / per-row YID tables, then multicasts each tagged packet
// to every PE whose IDs match, holding it until all targeted PEs have accepted.
module gin_multicast #(
  parameter int PE_H = 6,
  parameter int PE_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic [4:0]             cfg_xid,
  input  logic [2:0]             cfg_yid,
  output logic                   cfg_done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_tag_x,
  input  logic [2:0]             in_tag_y,
  input  logic [DATA_W-1:0]      in_data,
  output logic [PE_H*PE_W-1:0]   pe_valid,
  input  logic [PE_H*PE_W-1:0]   pe_ready,
  output logic [DATA_W-1:0]      pe_data,
  output logic                   miss
);
  localparam int N = PE_H * PE_W;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {CFG_IDLE, CFG_LOAD, RUN} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N*5-1:0]    xtab_q, xtab_d;
  logic [PE_H*3-1:0] ytab_q, ytab_d;
  logic              done_q, done_d, miss_q, miss_d;
  logic [N-1:0]      mask_q, mask_d, hit;
  logic [DATA_W-1:0] data_q, data_d;
  assign cfg_done = done_q;
  assign in_ready = (state_q == RUN) && ~|mask_q;
  assign pe_valid = mask_q;
  assign pe_data  = data_q;
  assign miss     = miss_q;
  // ID 31 / 7 marks a disabled entry and never matches, even against an equal tag
  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++)
      hit[i] = xtab_q[i*5 +: 5] == in_tag_x && ytab_q[(i/PE_W)*3 +: 3] == in_tag_y &&
               xtab_q[i*5 +: 5] != 5'd31 && ytab_q[(i/PE_W)*3 +: 3] != 3'd7;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xtab_d  = xtab_q;
    ytab_d  = ytab_q;
    done_d  = done_q;
    mask_d  = mask_q & ~pe_ready;
    data_d  = data_q;
    miss_d  = 1'b0;
    if (cfg_start) begin
      state_d = CFG_LOAD;
      cnt_d   = '0;
      done_d  = 1'b0;
      mask_d  = '0;
    end else if (state_q == CFG_LOAD && cfg_valid) begin
      xtab_d[cnt_q*5 +: 5] = cfg_xid;
      if (cnt_q % CW'(PE_W) == '0) ytab_d[(cnt_q / CW'(PE_W))*3 +: 3] = cfg_yid;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(N-1)) begin
        state_d = RUN;
        done_d  = 1'b1;
      end
    end else if (in_valid && in_ready) begin
      mask_d = hit;
      data_d = in_data;
      miss_d = ~|hit;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CFG_IDLE;
      cnt_q   <= '0;
      xtab_q  <= '1;
      ytab_q  <= '1;
      done_q  <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xtab_q  <= xtab_d;
      ytab_q  <= ytab_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      miss_q  <= miss_d;
    end
  end
endmodule

// File: doc/gin_multicast.md
GIN_MULTICAST -- requirements
Module: gin_multicast

Interface
REQ-001 Parameter PE_H, default 6, number of PE rows.
REQ-002 Parameter PE_W, default 8, number of PE columns; PE index i = row*PE_W + col, N = PE_H*PE_W = 48.
REQ-003 Parameter DATA_W, default 32, payload width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_start  input  1  one-cycle pulse that begins an ID-table load.
REQ-007 cfg_valid  input  1  current cfg_xid/cfg_yid word is valid.
REQ-008 cfg_xid  input  5  XID for the next PE in load order (31 means disabled).
REQ-009 cfg_yid  input  3  YID for the next PE row in load order (7 means disabled).
REQ-010 cfg_done  output  1  ID table fully loaded; held until the next cfg_start or rst.
REQ-011 in_valid  input  1  tagged packet present.
REQ-012 in_ready  output  1  block can accept a packet.
REQ-013 in_tag_x  input  5  destination XID.
REQ-014 in_tag_y  input  3  destination YID.
REQ-015 in_data  input  DATA_W  payload.
REQ-016 pe_valid  output  N  per-PE delivery request.
REQ-017 pe_ready  input  N  per-PE acceptance.
REQ-018 pe_data  output  DATA_W  payload broadcast to all PEs.
REQ-019 miss  output  1  one-cycle pulse when an accepted packet matches no PE.

Function
REQ-020 States: CFG_IDLE, CFG_LOAD, RUN. After reset the state is CFG_IDLE.
REQ-021 cfg_start in any state: enter CFG_LOAD, clear load counter, deassert cfg_done, drop any pending packet.
REQ-022 CFG_LOAD: each cfg_valid cycle writes XID table entry [cnt] and, when cnt%PE_W==0, YID table entry [cnt/PE_W]; cnt increments.
REQ-023 When a write lands at cnt==N-1: next cycle state=RUN, cfg_done=1. A cfg_valid received in that next cycle or later is ignored.
REQ-024 in_ready=1 only in RUN with no pending packet; in_ready=0 in CFG_IDLE and CFG_LOAD.
REQ-025 Accept on in_valid&in_ready at cycle T: latch data.
REQ-025 (cont.) Match mask bit i = (ytab[row(i)]==in_tag_y) & (xtab[i]==in_tag_x) & ytab[row(i)]!=7 & xtab[i]!=31.
REQ-026 Mask computation uses table contents at cycle T; pe_valid=mask and pe_data=latched data from T+1.
REQ-027 Bit i clears in the cycle after pe_valid[i]&pe_ready[i]. pe_data stays stable while any bit is set.
REQ-028 When the mask becomes all-zero, in_ready rises the same cycle, so back-to-back packets are spaced by 2 cycles minimum.
REQ-029 All-zero mask at accept: miss=1 at T+1, pe_valid stays 0, in_ready=1 at T+1.
REQ-030 pe_ready on bits with pe_valid=0 has no effect. Simultaneous readies clear all their bits in one cycle.
REQ-031 Tags 31/7 on input never match any PE.

Reset
REQ-032 rst=1 on a clock edge:
- state=CFG_IDLE, cfg_done=0, in_ready=0, pe_valid=0, pe_data=0, miss=0
- load counter=0
- XID table to 31, YID table to 7 (all disabled)
REQ-033 Reset mid-load or mid-delivery discards all progress; no pe_valid after the reset edge.

Verification
REQ-034 Load rows with YIDs 0..5 and XIDs 0..7 in every row; send tag (x=3, y=2) -> pe_valid only bit 19 at T+1; pe_ready[19] -> cleared, in_ready=1.
REQ-035 All 48 XIDs=0 and YIDs=0; send tag (0,0); assert pe_ready on even bits, then odd bits a cycle later -> mask 48'hFFFF_FFFF_FFFF -> 48'hAAAA_AAAA_AAAA -> 0; pe_data constant throughout.
REQ-036 Tag (5,6) with no row YID 6 -> miss pulse at T+1, pe_valid=0, in_ready=1 at T+1.
REQ-037 Load with row 1 YID=7 and XIDs identical to row 0; send tag (x, row-0 YID) -> only row-0 bits asserted. Input tag (31,7) -> miss.
REQ-038 cfg_start while a packet is pending with mask 0x3 -> pe_valid=0 next cycle, cfg_done=0, in_ready=0 until 48 more cfg_valid writes complete.
REQ-039 rst asserted after 20 cfg words -> cfg_done=0. A fresh full load then gives correct matches; words from the aborted load have no effect.
